// File: rtl/ex_operand_stage.sv
// Operand-select pipeline stage ahead of the ALU: one-entry register with
// valid/ready handshake, writeback bypass on capture and refresh while stalled.

package ex_params_pkg;
  localparam int WORD_SIZE  = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    OP_ALU_ADD  = 4'd0,
    OP_ALU_SUB  = 4'd1,
    OP_ALU_AND  = 4'd2,
    OP_ALU_OR   = 4'd3,
    OP_ALU_XOR  = 4'd4,
    OP_ALU_SLL  = 4'd5,
    OP_ALU_SRL  = 4'd6,
    OP_ALU_SRA  = 4'd7,
    OP_ALU_SLT  = 4'd8,
    OP_ALU_SLTU = 4'd9
  } alu_op;
endpackage

module ex_operand_stage
  import ex_params_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  alu_op                 in_alu_op_i,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr_i,
  input  logic [WORD_SIZE-1:0]  in_rs1_data_i,
  input  logic [WORD_SIZE-1:0]  in_rs2_data_i,
  input  logic [WORD_SIZE-1:0]  in_imm_i,
  input  logic [WORD_SIZE-1:0]  in_pc_i,
  input  logic                  in_a_sel_i,
  input  logic                  in_b_sel_i,
  input  logic [REG_ADDR_W-1:0] in_rd_addr_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [WORD_SIZE-1:0]  wb_data_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output alu_op                 out_alu_op_o,
  output logic [WORD_SIZE-1:0]  out_op_a_o,
  output logic [WORD_SIZE-1:0]  out_op_b_o,
  output logic [REG_ADDR_W-1:0] out_rd_addr_o
);

  logic                  valid_q,   valid_d;
  alu_op                 alu_op_q,  alu_op_d;
  logic [REG_ADDR_W-1:0] rs1_q,     rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q,     rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,      rd_d;
  logic                  a_sel_q,   a_sel_d;
  logic                  b_sel_q,   b_sel_d;
  logic [WORD_SIZE-1:0]  op_a_q,    op_a_d;
  logic [WORD_SIZE-1:0]  op_b_q,    op_b_d;

  logic                  accept;
  logic [WORD_SIZE-1:0]  rs1_eff, rs2_eff;

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  // x0 reads as zero ahead of any writeback match
  always_comb begin
    if (in_rs1_addr_i == '0)                      rs1_eff = '0;
    else if (wb_we_i && wb_rd_i == in_rs1_addr_i) rs1_eff = wb_data_i;
    else                                          rs1_eff = in_rs1_data_i;

    if (in_rs2_addr_i == '0)                      rs2_eff = '0;
    else if (wb_we_i && wb_rd_i == in_rs2_addr_i) rs2_eff = wb_data_i;
    else                                          rs2_eff = in_rs2_data_i;
  end

  always_comb begin
    valid_d  = valid_q;
    alu_op_d = alu_op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    a_sel_d  = a_sel_q;
    b_sel_d  = b_sel_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;

    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      alu_op_d = in_alu_op_i;
      rs1_d    = in_rs1_addr_i;
      rs2_d    = in_rs2_addr_i;
      rd_d     = in_rd_addr_i;
      a_sel_d  = in_a_sel_i;
      b_sel_d  = in_b_sel_i;
      op_a_d   = in_a_sel_i ? in_pc_i  : rs1_eff;
      op_b_d   = in_b_sel_i ? in_imm_i : rs2_eff;
    end else if (valid_q && !out_ready_i) begin
      // stalled: keep register operands coherent with the register file
      if (wb_we_i && wb_rd_i != '0 && wb_rd_i == rs1_q && !a_sel_q)
        op_a_d = wb_data_i;
      if (wb_we_i && wb_rd_i != '0 && wb_rd_i == rs2_q && !b_sel_q)
        op_b_d = wb_data_i;
    end else if (valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      alu_op_q <= OP_ALU_ADD;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      a_sel_q  <= 1'b0;
      b_sel_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      alu_op_q <= alu_op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      a_sel_q  <= a_sel_d;
      b_sel_q  <= b_sel_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign out_alu_op_o  = alu_op_q;
  assign out_op_a_o    = op_a_q;
  assign out_op_b_o    = op_b_q;
  assign out_rd_addr_o = rd_q;

endmodule
